iter_divider: RTL and testbench

- Parametrised radix-2 restoring divider for the execute stage of the in-order LoongArch pipeline.
- Replaces the fixed-width signed and unsigned vendor divider IP pair with one unit.
- Supports signed and unsigned operation, quotient and remainder, pipeline flush (exception/ertn), divide-by-zero fast path, and valid/ready on both sides.
- Execute stage holds its ready_go low until out_valid.

---
 rtl/iter_divider.sv | 154 +++++++++++++++
 tb/tb_iter_divider.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Radix-2 restoring divider for the execute stage. One quotient bit is
//   produced per clock, so a non-zero divisor takes WIDTH cycles from accept to
//   result. Handles signed and unsigned operands, returns quotient (truncated
//   toward zero) and remainder (sign of dividend). A zero divisor skips
//   iteration and returns quotient = all ones, remainder = dividend.
//
//   Handshake: a request transfers on a rising edge where in_valid & in_ready.
//   A result transfers on a rising edge where out_valid & out_ready. Neither
//   valid ever depends combinationally on the matching ready. in_ready is only
//   high in IDLE, so a new request cannot overlap a pending result.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 4)
//   CNT_W      iteration counter width, derived from WIDTH
//
// Ports
//   clk        clock
//   reset      synchronous active-high reset
//   flush      cancel any in-flight or completed division
//   in_valid   request valid
//   in_ready   unit can accept a request
//   op_signed  1 = signed, 0 = unsigned
//   dividend   dividend operand
//   divisor    divisor operand
//   out_valid  result valid
//   out_ready  consumer takes the result
//   quotient   quotient result
//   remainder  remainder result
//   busy       unit is not idle
// -----------------------------------------------------------------------------
module iter_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               sign_q;    // negate quotient at the end
    logic               sign_r;    // negate remainder at the end
    logic [WIDTH-1:0]   rem_acc;   // partial remainder
    logic [WIDTH-1:0]   quo_acc;   // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   dvs_mag;   // divisor magnitude

    // Operand magnitudes; in unsigned mode the operands are taken as-is.
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    assign dividend_neg = op_signed & dividend[WIDTH-1];
    assign divisor_neg  = op_signed & divisor[WIDTH-1];
    assign dividend_mag = dividend_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign divisor_mag  = divisor_neg  ? (~divisor  + WIDTH'(1)) : divisor;

    // One restoring step. Because rem_acc < dvs_mag, the difference lies in
    // (-2^WIDTH, 2^WIDTH), so a WIDTH+1-bit subtractor's top bit is the borrow.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

    assign shifted   = {rem_acc, quo_acc[WIDTH-1]};
    assign diff      = shifted - {1'b0, dvs_mag};
    assign no_borrow = ~diff[WIDTH];
    assign rem_next  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next  = {quo_acc[WIDTH-2:0], no_borrow};
    assign q_fixed   = sign_q ? (~quo_next + WIDTH'(1)) : quo_next;
    assign r_fixed   = sign_r ? (~rem_next + WIDTH'(1)) : rem_next;

    assign in_ready  = (state == IDLE) & ~flush & ~reset;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            dvs_mag   <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            // Result registers are deliberately left alone.
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= dividend_neg ^ divisor_neg;
                        sign_r <= dividend_neg;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            state     <= DONE;
                        end else begin
                            rem_acc <= '0;
                            quo_acc <= dividend_mag;
                            dvs_mag <= divisor_mag;
                            counter <= '0;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_acc <= rem_next;
                    quo_acc <= quo_next;
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        quotient  <= q_fixed;
                        remainder <= r_fixed;
                        state     <= DONE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// -----------------------------------------------------------------------------
// tb_iter_divider
//   Directed bench for iter_divider with a 32-bit and an 8-bit instance.
//   Latency is counted as rising edges after the accepting edge until out_valid
//   is seen (0 for the divide-by-zero path, WIDTH for a normal division).
// -----------------------------------------------------------------------------
module tb_iter_divider;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        reset, flush, in_valid, op_signed, out_ready;
    logic [31:0] dividend, divisor;
    logic        in_ready, out_valid, busy;
    logic [31:0] quotient, remainder;

    // 8-bit instance signals
    logic        reset8, flush8, in_valid8, op_signed8, out_ready8;
    logic [7:0]  dividend8, divisor8;
    logic        in_ready8, out_valid8, busy8;
    logic [7:0]  quotient8, remainder8;

    iter_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op_signed(op_signed),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .busy(busy)
    );

    iter_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .op_signed(op_signed8),
        .dividend(dividend8), .divisor(divisor8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .quotient(quotient8), .remainder(remainder8), .busy(busy8)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks: 32-bit ----------------
    task automatic issue32(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_signed = s; dividend = a; divisor = b; in_valid = 1'b1;
        check("in_ready_at_issue32", {31'd0, in_ready}, 32'd1);
        @(posedge clk);                 // accepting edge
        @(negedge clk);
        in_valid  = 1'b0;
        dividend  = $urandom;           // later input changes must be ignored
        divisor   = $urandom;
        op_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait32(input string tag, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er);
        int lat;
        lat = -1;
        if (out_valid) lat = 0;
        for (int i = 1; i <= 100 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) lat = i;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
    endtask

    task automatic ack32(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_after_ack"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready_after_ack"}, {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- driver tasks: 8-bit ----------------
    task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op_signed8 = s; dividend8 = a; divisor8 = b; in_valid8 = 1'b1;
        check("in_ready_at_issue8", {31'd0, in_ready8}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        dividend8 = 8'($urandom);
        divisor8  = 8'($urandom);
    endtask

    task automatic wait8(input string tag, input int exp_lat,
                         input logic [7:0] eq, input logic [7:0] er);
        int lat;
        lat = -1;
        if (out_valid8) lat = 0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid8) lat = i;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_q"}, {24'd0, quotient8}, {24'd0, eq});
        check({tag, "_r"}, {24'd0, remainder8}, {24'd0, er});
    endtask

    task automatic ack8();
        @(negedge clk);
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready8 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ov_seen;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op_signed = 1'b0;
        out_ready = 1'b0; dividend = '0; divisor = '0;
        reset8 = 1'b1; flush8 = 1'b0; in_valid8 = 1'b0; op_signed8 = 1'b0;
        out_ready8 = 1'b0; dividend8 = '0; divisor8 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_q",         quotient,           32'd0);
        check("rst_r",         remainder,          32'd0);
        reset = 1'b0; reset8 = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Unsigned and signed basics
        issue32(1'b0, 32'd100, 32'd7);
        wait32("u100_7", 32, 32'd14, 32'd2);
        ack32("u100_7");

        issue32(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait32("s_m7_2", 32, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        ack32("s_m7_2");

        issue32(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait32("s_7_m2", 32, 32'hFFFF_FFFD, 32'd1);
        ack32("s_7_m2");

        issue32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait32("s_min_m1", 32, 32'h8000_0000, 32'd0);
        ack32("s_min_m1");

        // Unsigned mode must not sign-extend
        issue32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait32("u_big", 32, 32'd0, 32'h8000_0000);
        ack32("u_big");

        issue32(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait32("u_max_16", 32, 32'h0FFF_FFFF, 32'hF);
        ack32("u_max_16");

        // Divide by zero, both modes
        issue32(1'b1, 32'h1234, 32'd0);
        wait32("s_div0", 0, 32'hFFFF_FFFF, 32'h1234);
        ack32("s_div0");

        issue32(1'b0, 32'h1234, 32'd0);
        wait32("u_div0", 0, 32'hFFFF_FFFF, 32'h1234);
        ack32("u_div0");

        // Flush in the 10th CALC cycle, with a request presented alongside
        issue32(1'b0, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; dividend = 32'd5; divisor = 32'd1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        check("flush_in_ready_after", {31'd0, in_ready}, 32'd1);
        ov_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("flush_no_out_valid", 32'(ov_seen), 32'd0);

        issue32(1'b0, 32'd9, 32'd3);
        wait32("u9_3", 32, 32'd3, 32'd0);
        ack32("u9_3");

        // Flush while a result is waiting
        issue32(1'b0, 32'd50, 32'd5);
        wait32("u50_5", 32, 32'd10, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_ov", {31'd0, out_valid}, 32'd0);
        check("flush_done_busy", {31'd0, busy}, 32'd0);

        // Backpressure with a new request held pending
        issue32(1'b0, 32'd100, 32'd9);
        wait32("u100_9", 32, 32'd11, 32'd1);
        @(negedge clk);
        in_valid = 1'b1; op_signed = 1'b0; dividend = 32'd77; divisor = 32'd4;
        for (int i = 0; i < 5; i++) begin
            check("bp_ov", {31'd0, out_valid}, 32'd1);
            check("bp_q", quotient, 32'd11);
            check("bp_r", remainder, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);                 // result handshake
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("bp_ov_after", {31'd0, out_valid}, 32'd0);
        @(posedge clk);                 // held request accepted here
        @(negedge clk);
        in_valid = 1'b0;
        wait32("u77_4", 32, 32'd19, 32'd1);
        ack32("u77_4");

        // 8-bit instance
        issue8(1'b0, 8'd200, 8'd7);
        wait8("w8_u200_7", 8, 8'd28, 8'd4);
        ack8();

        issue8(1'b1, 8'h80, 8'hFF);
        wait8("w8_s_min_m1", 8, 8'h80, 8'h00);
        ack8();

        issue8(1'b1, 8'hF9, 8'd2);
        wait8("w8_s_m7_2", 8, 8'hFD, 8'hFF);
        ack8();

        // Reset mid-CALC clears the result registers
        issue8(1'b0, 8'd200, 8'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset8 = 1'b1;
        #1;
        check("w8_rst_in_ready", {31'd0, in_ready8}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset8 = 1'b0;
        #1;
        check("w8_rst_busy", {31'd0, busy8}, 32'd0);
        check("w8_rst_ov", {31'd0, out_valid8}, 32'd0);
        check("w8_rst_q", {24'd0, quotient8}, 32'd0);
        check("w8_rst_r", {24'd0, remainder8}, 32'd0);
        check("w8_rst_in_ready_after", {31'd0, in_ready8}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
